// File: rtl/alu_pkg.sv
// Shared constants and encodings for the ALU retire stage.
package alu_pkg;

   localparam int WIDTH  = 20;
   localparam int REG_AW = 4;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_S = 2;

   typedef enum logic [2:0] {
      K_RESULT = 3'd0,
      K_CMP    = 3'd1,
      K_LSR    = 3'd2,
      K_XSR    = 3'd3,
      K_JMP    = 3'd4,
      K_JZ     = 3'd5,
      K_JS     = 3'd6,
      K_JZS    = 3'd7
   } kind_t;

endpackage

// File: rtl/alu_retire_if.sv
// ALU-outcome input handshake plus writeback, status and branch outputs.
interface alu_retire_if;
   import alu_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_kind;
   logic [WIDTH-1:0]  in_data;
   logic [REG_AW-1:0] in_dest;
   logic [2:0]        in_flag_we;
   logic              in_zero;
   logic              in_carry;
   logic              in_sign;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [REG_AW-1:0] out_dest;
   logic [2:0]        status;
   logic              br_valid;
   logic [WIDTH-1:0]  br_target;

   modport master (
      output in_valid, in_kind, in_data, in_dest, in_flag_we,
             in_zero, in_carry, in_sign, out_ready,
      input  in_ready, out_valid, out_data, out_dest, status,
             br_valid, br_target
   );

   modport slave (
      input  in_valid, in_kind, in_data, in_dest, in_flag_we,
             in_zero, in_carry, in_sign, out_ready,
      output in_ready, out_valid, out_data, out_dest, status,
             br_valid, br_target
   );

endinterface

// File: rtl/retire_fifo.sv
// Two-entry FIFO toward writeback; head is read straight from storage, no bypass.
module retire_fifo #(
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic [1:0]    count_o
);

   logic [DW-1:0] mem_q [2];
   logic          wr_q;
   logic          rd_q;
   logic [1:0]    count_q;
   logic [1:0]    count_d;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && (count_q != 2'd2);
   assign do_pop  = pop_i && (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 2'd1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ~wr_q;
         end
         if (do_pop) begin
            rd_q <= ~rd_q;
         end
         count_q <= count_d;
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/alu_retire.sv
// Retire stage: maintains {S,C,Z}, resolves jumps, buffers register results.
module alu_retire
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   alu_retire_if.slave bus
);

   logic [2:0]        status_q, status_d;
   logic              br_valid_q, br_valid_d;
   logic [WIDTH-1:0]  br_target_q, br_target_d;
   logic [1:0]        count;
   logic              accept;
   logic              push;
   logic              pop;
   logic              taken;
   logic [WIDTH+REG_AW-1:0] head;
   kind_t             kind;

   assign kind   = kind_t'(bus.in_kind);
   // Ready comes only from the registered count, never from out_ready.
   assign bus.in_ready = (count != 2'd2);
   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && (kind == K_RESULT);
   assign pop    = bus.out_valid && bus.out_ready;

   always_comb begin
      taken = 1'b0;
      case (kind)
         K_JMP:   taken = 1'b1;
         K_JZ:    taken = status_q[FLAG_Z];
         K_JS:    taken = status_q[FLAG_S];
         K_JZS:   taken = status_q[FLAG_Z] | status_q[FLAG_S];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      status_d    = status_q;
      br_valid_d  = 1'b0;
      br_target_d = br_target_q;
      if (accept) begin
         case (kind)
            K_RESULT, K_CMP: begin
               if (bus.in_flag_we[FLAG_Z]) status_d[FLAG_Z] = bus.in_zero;
               if (bus.in_flag_we[FLAG_C]) status_d[FLAG_C] = bus.in_carry;
               if (bus.in_flag_we[FLAG_S]) status_d[FLAG_S] = bus.in_sign;
            end
            K_LSR:   status_d = bus.in_data[2:0];
            K_XSR:   status_d = status_q ^ bus.in_data[2:0];
            default: begin
               if (taken) begin
                  br_valid_d  = 1'b1;
                  br_target_d = bus.in_data;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q    <= 3'b000;
         br_valid_q  <= 1'b0;
         br_target_q <= '0;
      end else begin
         status_q    <= status_d;
         br_valid_q  <= br_valid_d;
         br_target_q <= br_target_d;
      end
   end

   retire_fifo #(.DW(WIDTH + REG_AW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  ({bus.in_data, bus.in_dest}),
      .data_o  (head),
      .count_o (count)
   );

   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = head[WIDTH+REG_AW-1:REG_AW];
   assign bus.out_dest  = head[REG_AW-1:0];
   assign bus.status    = status_q;
   assign bus.br_valid  = br_valid_q;
   assign bus.br_target = br_target_q;

endmodule

// File: tb/tb_alu_retire.sv
// Bench for alu_retire: directed vector table, hand sequences, randomized model check.
module tb_alu_retire;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_retire_if bus ();

   alu_retire dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [2:0]  kind;
      logic [19:0] data;
      logic [3:0]  dest;
      logic [2:0]  we;
      logic        z, c, s;
      logic [2:0]  exp_status;
      logic        exp_br;
      logic [19:0] exp_tgt;
      logic        exp_ov;
      logic [19:0] exp_data;
      logic [3:0]  exp_dest;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] k, input logic [19:0] d,
                        input logic [3:0] dst, input logic [2:0] we,
                        input logic z, input logic c, input logic s);
      bus.in_valid   = v;
      bus.in_kind    = k;
      bus.in_data    = d;
      bus.in_dest    = dst;
      bus.in_flag_we = we;
      bus.in_zero    = z;
      bus.in_carry   = c;
      bus.in_sign    = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 3'd0, 20'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model state
   logic [23:0] m_q [$];
   logic [2:0]  m_status;
   logic        m_br;
   logic [19:0] m_tgt;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{K_RESULT, 20'h0000F, 4'd3,  3'b111, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 20'h00000, 1'b1, 20'h0000F, 4'd3};
      vecs[1]  = '{K_LSR,    20'h00005, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 20'h00000, 1'b0, 20'h0, 4'd0};
      vecs[2]  = '{K_XSR,    20'h00007, 4'd0,  3'b111, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 20'h00000, 1'b0, 20'h0, 4'd0};
      vecs[3]  = '{K_CMP,    20'h00000, 4'd0,  3'b001, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0, 20'h00000, 1'b0, 20'h0, 4'd0};
      vecs[4]  = '{K_JZ,     20'h00100, 4'd0,  3'b111, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 20'h00100, 1'b0, 20'h0, 4'd0};
      vecs[5]  = '{K_JS,     20'h00200, 4'd0,  3'b111, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 20'h00100, 1'b0, 20'h0, 4'd0};
      vecs[6]  = '{K_LSR,    20'hFFFF4, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 20'h00100, 1'b0, 20'h0, 4'd0};
      vecs[7]  = '{K_JZS,    20'h00300, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 20'h00300, 1'b0, 20'h0, 4'd0};
      vecs[8]  = '{K_LSR,    20'h00000, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 20'h00300, 1'b0, 20'h0, 4'd0};
      vecs[9]  = '{K_JZS,    20'h00400, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 20'h00300, 1'b0, 20'h0, 4'd0};
      vecs[10] = '{K_JMP,    20'h00555, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 20'h00555, 1'b0, 20'h0, 4'd0};
      vecs[11] = '{K_CMP,    20'h00000, 4'd0,  3'b100, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 20'h00555, 1'b0, 20'h0, 4'd0};
      vecs[12] = '{K_RESULT, 20'h12345, 4'd9,  3'b000, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 20'h00555, 1'b1, 20'h12345, 4'd9};
      vecs[13] = '{K_XSR,    20'h00007, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 20'h00555, 1'b0, 20'h0, 4'd0};
      vecs[14] = '{K_JS,     20'h00777, 4'd0,  3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 20'h00555, 1'b0, 20'h0, 4'd0};
      vecs[15] = '{K_RESULT, 20'hAAAAA, 4'd15, 3'b011, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 20'h00555, 1'b1, 20'hAAAAA, 4'd15};
      vecs[16] = '{K_JZS,    20'h00888, 4'd0,  3'b111, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 20'h00555, 1'b0, 20'h0, 4'd0};

      bus.out_ready = 1'b1;
      do_reset();

      // Reset state
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_dest",  32'(bus.out_dest),  32'd0);
      chk("rst_status",    32'(bus.status),    32'd0);
      chk("rst_br_valid",  32'(bus.br_valid),  32'd0);
      chk("rst_br_target", 32'(bus.br_target), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

      // Directed vector table, back-to-back accepts with writeback always ready
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, vecs[i].kind, vecs[i].data, vecs[i].dest, vecs[i].we,
               vecs[i].z, vecs[i].c, vecs[i].s);
         @(negedge clk);
         chk($sformatf("vec%0d_status", i), 32'(bus.status),    32'(vecs[i].exp_status));
         chk($sformatf("vec%0d_br",     i), 32'(bus.br_valid),  32'(vecs[i].exp_br));
         chk($sformatf("vec%0d_tgt",    i), 32'(bus.br_target), 32'(vecs[i].exp_tgt));
         chk($sformatf("vec%0d_ov",     i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) begin
            chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_dest", i), 32'(bus.out_dest), 32'(vecs[i].exp_dest));
         end
      end
      drive(1'b0, 3'd0, 20'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("idle_br_clear", 32'(bus.br_valid), 32'd0);
      chk("idle_fifo_empty", 32'(bus.out_valid), 32'd0);

      // Back-pressure: fill, stall third, drain in order
      bus.out_ready = 1'b0;
      chk("bp_ready0", 32'(bus.in_ready), 32'd1);
      drive(1'b1, K_RESULT, 20'h00011, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_ready1", 32'(bus.in_ready), 32'd1);
      chk("bp_head_a", 32'(bus.out_data), 32'h11);
      drive(1'b1, K_RESULT, 20'h00022, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, K_RESULT, 20'h00033, 4'd3, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_still_full", 32'(bus.in_ready), 32'd0);
      chk("bp_stable_data", 32'(bus.out_data), 32'h11);
      chk("bp_stable_dest", 32'(bus.out_dest), 32'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_pop1_data", 32'(bus.out_data), 32'h22);
      chk("bp_pop1_dest", 32'(bus.out_dest), 32'd2);
      chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 3'd0, 20'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("bp_pop2_data", 32'(bus.out_data), 32'h33);
      chk("bp_pop2_dest", 32'(bus.out_dest), 32'd3);
      chk("bp_pop2_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      chk("bp_drained", 32'(bus.out_valid), 32'd0);

      // Reset with a full FIFO and all flags set
      bus.out_ready = 1'b0;
      drive(1'b1, K_LSR, 20'h00007, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, K_RESULT, 20'h00001, 4'd1, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, K_RESULT, 20'h00002, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 3'd0, 20'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_status", 32'(bus.status), 32'h7);
      chk("pre_rst_ready",  32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ov",     32'(bus.out_valid), 32'd0);
      chk("mid_rst_status", 32'(bus.status),    32'd0);
      chk("mid_rst_ready",  32'(bus.in_ready),  32'd1);
      chk("mid_rst_br",     32'(bus.br_valid),  32'd0);
      chk("mid_rst_data",   32'(bus.out_data),  32'd0);

      // Randomized run against a queue-based model
      do_reset();
      m_q.delete();
      m_status = 3'b000;
      m_br = 1'b0;
      m_tgt = 20'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic       v, ordy, acc, tk;
         logic [2:0] k, we;
         logic [19:0] d;
         logic [3:0] dst;
         logic       z, c, s;
         logic [2:0] flags;

         chk("rnd_in_ready",  32'(bus.in_ready),  32'(m_q.size() != 2));
         chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            chk("rnd_out_word", 32'({bus.out_data, bus.out_dest}), 32'(m_q[0]));
         end
         chk("rnd_status",    32'(bus.status),    32'(m_status));
         chk("rnd_br_valid",  32'(bus.br_valid),  32'(m_br));
         chk("rnd_br_target", 32'(bus.br_target), 32'(m_tgt));

         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         k    = 3'($urandom_range(0, 7));
         d    = 20'($urandom);
         dst  = 4'($urandom);
         we   = 3'($urandom);
         z    = 1'($urandom);
         c    = 1'($urandom);
         s    = 1'($urandom);
         drive(v, k, d, dst, we, z, c, s);
         bus.out_ready = ordy;

         acc = v && (m_q.size() < 2);
         flags = {s, c, z};
         tk = 1'b0;
         if (acc) begin
            if (k == K_JMP) tk = 1'b1;
            if (k == K_JZ)  tk = m_status[0];
            if (k == K_JS)  tk = m_status[2];
            if (k == K_JZS) tk = m_status[0] || m_status[2];
         end
         if (ordy && m_q.size() != 0) void'(m_q.pop_front());
         if (acc) begin
            if (k == K_RESULT || k == K_CMP) begin
               for (int b = 0; b < 3; b++) begin
                  if (we[b]) m_status[b] = flags[b];
               end
            end else if (k == K_LSR) begin
               m_status = d[2:0];
            end else if (k == K_XSR) begin
               m_status = m_status ^ d[2:0];
            end
            if (k == K_RESULT) m_q.push_back({d, dst});
         end
         m_br = tk;
         if (tk) m_tgt = d;
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_retire.md
# alu_retire

Retire stage directly downstream of the 20-bit ALU. It accepts one ALU outcome per cycle over a valid/ready handshake and maintains the architectural status register {S, C, Z}. It also executes the status-register program flows (load, XOR) and resolves the jump program flows (JMP, JZ, JS, JZS) against that register. Register-file results are buffered in a 2-entry FIFO toward writeback, so a stalled writeback does not immediately back-pressure the ALU.

## Interface
- WIDTH, 20, datapath width; matches the ALU.
- REG_AW, 4, destination register index width.

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU outcome present
- in_ready  out  1  stage can accept; equals (count != 2)
- in_kind  in  3  0 RESULT, 1 CMP, 2 LSR, 3 XSR, 4 JMP, 5 JZ, 6 JS, 7 JZS
- in_data  in  WIDTH  ALU result, jump target, or status operand, depending on kind
- in_dest  in  REG_AW  destination register; RESULT only
- in_flag_we  in  3  per-flag write enable, {S, C, Z}; RESULT and CMP only
- in_zero, in_carry, in_sign  in  1 each  ALU flag outputs
- out_valid  out  1  writeback entry available
- out_ready  in  1  writeback consumes the head entry
- out_data  out  WIDTH  head entry result
- out_dest  out  REG_AW  head entry destination
- status  out  3  registered {S, C, Z}
- br_valid  out  1  one-cycle taken-branch pulse
- br_target  out  WIDTH  target of the taken branch

## Operation
- Accept: an outcome is accepted when in_valid && in_ready are both high at a rising edge.
- RESULT:
  - Pushes {in_data, in_dest} into the FIFO.
  - For each bit set in in_flag_we, the corresponding status bit takes the ALU flag.
- CMP: flag update exactly as for RESULT; no FIFO push.
- LSR: status <= in_data[2:0]. in_flag_we is ignored.
- XSR: status <= status ^ in_data[2:0]. in_flag_we is ignored.
- Jumps are evaluated against the registered status value at the accept edge. That value already includes every earlier accepted outcome.
  - JMP: always taken.
  - JZ: taken if Z.
  - JS: taken if S.
  - JZS: taken if Z | S.
  - Jumps never modify status.
- Taken jump: br_valid = 1 and br_target = in_data in the cycle after the accept. br_valid then returns to 0 unless another taken jump was accepted.
- Not-taken jump: br_valid stays 0 and br_target holds its previous value.
- FIFO:
  - count ranges 0..2.
  - out_valid = (count != 0).
  - Pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged and preserve order.
  - When count == 2, in_ready = 0 even if a pop happens that cycle; there is no combinational ready path from out_ready.
- in_ready does not depend on in_kind: every kind stalls while the FIFO is full.

## Timing
- Reset values: count 0, out_valid 0, out_data 0, out_dest 0, status 3'b000, br_valid 0, br_target 0.
- in_ready is 1 in the first cycle after reset.
- Reset in the middle of operation discards both FIFO entries and any pending branch pulse in the same edge.
- Latency, RESULT: accepted at edge N, visible on out_* from cycle N+1 when the FIFO was empty. The FIFO has no bypass path.
- Latency, status: status reflects a RESULT, CMP, LSR or XSR accepted at edge N from cycle N+1.
- Back-to-back: a CMP at edge N followed by a JZ at edge N+1 sees the CMP's Z.
- Back-pressure: out_data and out_dest stay stable while out_valid && !out_ready.
- Throughput: one accept per cycle while count < 2.

## Structure
- Package alu_pkg holds:
  - WIDTH
  - kind encodings as a 3-bit enum kind_t
  - status bit indices FLAG_Z = 0, FLAG_C = 1, FLAG_S = 2
- The top level holds status-update logic, branch resolution and the handshake.
- The 2-entry FIFO is a sub-module, retire_fifo, parameterised by the data width (WIDTH + REG_AW).

## Test plan
- RESULT with data 20'h0000F, dest 3, flag_we 3'b111, flags Z=0 C=1 S=0 and out_ready=1 -> next cycle out_valid=1, out_data=20'h0000F, out_dest=3, status=3'b010.
- Hold out_ready=0 and send 3 RESULTs -> first two accepted, in_ready=0 on the third. Raise out_ready -> entries pop in order, and in_ready rises the cycle after the first pop.
- LSR with in_data=20'h00005 then XSR with in_data=20'h00007 -> status 3'b101, then 3'b010.
- CMP with Z=1, flag_we=3'b001, then JZ with in_data=20'h00100 on the next cycle -> br_valid pulses for one cycle with br_target=20'h00100. A following JS, with S=0, -> no pulse.
- JZS with status 3'b100 -> taken. JZS with status 3'b000 -> br_valid stays 0.
- rst asserted with count=2 and status=3'b111 -> next cycle out_valid=0, status=0, in_ready=1, br_valid=0.
